// File: rtl/doraemon_select_core.sv
// Door-slot selection engine: fills NUM_DOOR slots, then each new beat replaces the
// highest weighted-score slot (lowest index wins ties); drain empties slots best-first.
module doraemon_select_core #(
    parameter int NUM_DOOR = 5,
    parameter int DOOR_W   = 3,
    parameter int ID_W     = 5,
    parameter int SCORE_W  = 8,
    parameter int WEIGHT_W = 3
) (
    input  logic                   clk1,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic                   drain,
    input  logic [ID_W-1:0]        doraemon_id,
    input  logic [SCORE_W-1:0]     size,
    input  logic [SCORE_W-1:0]     iq_score,
    input  logic [SCORE_W-1:0]     eq_score,
    input  logic [WEIGHT_W-1:0]    size_weight,
    input  logic [WEIGHT_W-1:0]    iq_weight,
    input  logic [WEIGHT_W-1:0]    eq_weight,
    output logic                   ready,
    output logic                   out_valid,
    output logic [DOOR_W+ID_W-1:0] out,
    output logic [1:0]             fsm_state
);
    localparam int SCW   = SCORE_W + WEIGHT_W + 2;
    localparam int CNT_W = $clog2(NUM_DOOR + 1);

    typedef enum logic [1:0] {FILL = 2'd0, RUN = 2'd1, CALC = 2'd2, DRAIN = 2'd3} state_t;
    state_t state, state_next;

    logic [NUM_DOOR-1:0] slot_vld;
    logic [ID_W-1:0]     slot_id   [NUM_DOOR];
    logic [SCORE_W-1:0]  slot_size [NUM_DOOR];
    logic [SCORE_W-1:0]  slot_iq   [NUM_DOOR];
    logic [SCORE_W-1:0]  slot_eq   [NUM_DOOR];
    logic [CNT_W-1:0]    count;
    logic [WEIGHT_W-1:0] w_size, w_iq, w_eq;
    logic [ID_W-1:0]     hold_id;
    logic [SCORE_W-1:0]  hold_size, hold_iq, hold_eq;

    logic                accept, drain_go;
    logic [SCW-1:0]      score [NUM_DOOR];
    logic [DOOR_W-1:0]   best_idx, free_idx;
    logic [SCW-1:0]      best_score;
    logic                best_found;

    // ready is registered, so a beat and a drain are both qualified on the same ready cycle
    assign accept    = ready & in_valid;
    assign drain_go  = ready & ~in_valid & drain & (count != '0);
    assign fsm_state = state;

    always_comb begin
        for (int i = 0; i < NUM_DOOR; i++) begin
            score[i] = SCW'(slot_size[i]) * SCW'(w_size)
                     + SCW'(slot_iq[i])   * SCW'(w_iq)
                     + SCW'(slot_eq[i])   * SCW'(w_eq);
        end
    end

    // Strict greater-than keeps the lowest index on a tie
    always_comb begin
        best_idx   = '0;
        best_score = '0;
        best_found = 1'b0;
        for (int i = 0; i < NUM_DOOR; i++) begin
            if (slot_vld[i] && (!best_found || score[i] > best_score)) begin
                best_found = 1'b1;
                best_idx   = DOOR_W'(i);
                best_score = score[i];
            end
        end
    end

    always_comb begin
        free_idx = '0;
        for (int i = NUM_DOOR - 1; i >= 0; i--) begin
            if (!slot_vld[i]) free_idx = DOOR_W'(i);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            FILL: begin
                if (accept && count == CNT_W'(NUM_DOOR - 1)) state_next = RUN;
                else if (drain_go)                           state_next = DRAIN;
            end
            RUN: begin
                if (accept)        state_next = CALC;
                else if (drain_go) state_next = DRAIN;
            end
            CALC:  state_next = RUN;
            DRAIN: if (count == CNT_W'(1)) state_next = FILL;
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) state <= FILL;
        else        state <= state_next;
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            ready     <= 1'b0;
            out_valid <= 1'b0;
            out       <= '0;
            count     <= '0;
            slot_vld  <= '0;
            w_size    <= '0;
            w_iq      <= '0;
            w_eq      <= '0;
            hold_id   <= '0;
            hold_size <= '0;
            hold_iq   <= '0;
            hold_eq   <= '0;
            for (int i = 0; i < NUM_DOOR; i++) begin
                slot_id[i]   <= '0;
                slot_size[i] <= '0;
                slot_iq[i]   <= '0;
                slot_eq[i]   <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            out       <= '0;
            ready     <= (state_next == FILL) || (state_next == RUN);
            if (accept) begin
                w_size <= size_weight;
                w_iq   <= iq_weight;
                w_eq   <= eq_weight;
            end
            case (state)
                FILL: begin
                    if (accept) begin
                        slot_vld[free_idx]  <= 1'b1;
                        slot_id[free_idx]   <= doraemon_id;
                        slot_size[free_idx] <= size;
                        slot_iq[free_idx]   <= iq_score;
                        slot_eq[free_idx]   <= eq_score;
                        count               <= count + CNT_W'(1);
                    end
                end
                RUN: begin
                    if (accept) begin
                        hold_id   <= doraemon_id;
                        hold_size <= size;
                        hold_iq   <= iq_score;
                        hold_eq   <= eq_score;
                    end
                end
                CALC: begin
                    out_valid           <= 1'b1;
                    out                 <= {best_idx, slot_id[best_idx]};
                    slot_id[best_idx]   <= hold_id;
                    slot_size[best_idx] <= hold_size;
                    slot_iq[best_idx]   <= hold_iq;
                    slot_eq[best_idx]   <= hold_eq;
                end
                DRAIN: begin
                    out_valid          <= 1'b1;
                    out                <= {best_idx, slot_id[best_idx]};
                    slot_vld[best_idx] <= 1'b0;
                    count              <= count - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_doraemon_select_core.sv
// Randomised bench for doraemon_select_core: a slot-list reference model predicts each
// selection and its output cycle; a monitor pops the expectations as outputs appear.
module tb_doraemon_select_core;
    localparam int NUM_DOOR = 5;
    localparam int DOOR_W   = 3;
    localparam int ID_W     = 5;
    localparam int SCORE_W  = 8;
    localparam int WEIGHT_W = 3;
    localparam int OW       = DOOR_W + ID_W;

    logic                clk1 = 1'b0;
    logic                rst_n = 1'b0;
    logic                in_valid = 1'b0;
    logic                drain = 1'b0;
    logic [ID_W-1:0]     doraemon_id = '0;
    logic [SCORE_W-1:0]  size = '0, iq_score = '0, eq_score = '0;
    logic [WEIGHT_W-1:0] size_weight = '0, iq_weight = '0, eq_weight = '0;
    logic                ready, out_valid;
    logic [OW-1:0]       out;
    logic [1:0]          fsm_state;

    doraemon_select_core #(
        .NUM_DOOR(NUM_DOOR), .DOOR_W(DOOR_W), .ID_W(ID_W),
        .SCORE_W(SCORE_W), .WEIGHT_W(WEIGHT_W)
    ) dut (
        .clk1(clk1), .rst_n(rst_n), .in_valid(in_valid), .drain(drain),
        .doraemon_id(doraemon_id), .size(size), .iq_score(iq_score), .eq_score(eq_score),
        .size_weight(size_weight), .iq_weight(iq_weight), .eq_weight(eq_weight),
        .ready(ready), .out_valid(out_valid), .out(out), .fsm_state(fsm_state)
    );

    // clock/reset block
    always #5 clk1 = ~clk1;
    int cyc = 0;
    always @(posedge clk1) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    logic [OW-1:0] exp_q[$];
    int            exp_cyc_q[$];

    // reference model: plain slot list plus how many cycles ready should stay low
    int m_vld[NUM_DOOR], m_id[NUM_DOOR], m_sz[NUM_DOOR], m_iq[NUM_DOOR], m_eq[NUM_DOOR];
    int m_cnt, m_ws, m_wi, m_we, m_busy;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int m_score(input int i);
        return m_sz[i] * m_ws + m_iq[i] * m_wi + m_eq[i] * m_we;
    endfunction

    function automatic int m_pick();
        int b = -1;
        for (int i = 0; i < NUM_DOOR; i++)
            if (m_vld[i] != 0 && (b < 0 || m_score(i) > m_score(b))) b = i;
        return b;
    endfunction

    task automatic m_expect(input int b, input int at);
        logic [OW-1:0] e;
        logic [31:0]   bv, iv;
        bv = b;
        iv = m_id[b];
        e  = {bv[DOOR_W-1:0], iv[ID_W-1:0]};
        exp_q.push_back(e);
        exp_cyc_q.push_back(at);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_DOOR; i++) begin
            m_vld[i] = 0; m_id[i] = 0; m_sz[i] = 0; m_iq[i] = 0; m_eq[i] = 0;
        end
        m_cnt = 0; m_ws = 0; m_wi = 0; m_we = 0; m_busy = 0;
        exp_q.delete();
        exp_cyc_q.delete();
    endtask

    // driver: present one cycle of inputs and advance the model if the DUT should take them
    task automatic step(input bit v, input bit d, input int id, input int sz, input int iq,
                        input int eq, input int ws, input int wi, input int we);
        logic [31:0] idv, szv, iqv, eqv, wsv, wiv, wev;
        int b, f, k;
        idv = id; szv = sz; iqv = iq; eqv = eq; wsv = ws; wiv = wi; wev = we;
        @(negedge clk1);
        in_valid    = v;
        drain       = d;
        doraemon_id = idv[ID_W-1:0];
        size        = szv[SCORE_W-1:0];
        iq_score    = iqv[SCORE_W-1:0];
        eq_score    = eqv[SCORE_W-1:0];
        size_weight = wsv[WEIGHT_W-1:0];
        iq_weight   = wiv[WEIGHT_W-1:0];
        eq_weight   = wev[WEIGHT_W-1:0];
        check("ready", int'(ready), int'(m_busy == 0));
        if (m_busy > 0) begin
            m_busy--;
        end else if (v) begin
            m_ws = ws; m_wi = wi; m_we = we;
            if (m_cnt < NUM_DOOR) begin
                f = -1;
                for (int i = NUM_DOOR - 1; i >= 0; i--) if (m_vld[i] == 0) f = i;
                m_vld[f] = 1; m_id[f] = id; m_sz[f] = sz; m_iq[f] = iq; m_eq[f] = eq;
                m_cnt++;
            end else begin
                b = m_pick();
                m_expect(b, cyc + 2);
                m_id[b] = id; m_sz[b] = sz; m_iq[b] = iq; m_eq[b] = eq;
                m_busy = 1;
            end
        end else if (d && m_cnt > 0) begin
            k = m_cnt;
            for (int j = 0; j < k; j++) begin
                b = m_pick();
                m_expect(b, cyc + 2 + j);
                m_vld[b] = 0;
            end
            m_cnt  = 0;
            m_busy = k;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rand_step(input bit v, input bit d);
        step(v, d, $urandom_range(0, 31), $urandom_range(0, 255), $urandom_range(0, 255),
             $urandom_range(0, 255), $urandom_range(0, 7), $urandom_range(0, 7),
             $urandom_range(0, 7));
    endtask

    task automatic do_reset();
        @(posedge clk1);
        #2;
        rst_n = 1'b0;
        in_valid = 1'b0;
        drain = 1'b0;
        #1;
        check("rst_out", int'(out), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_ready", int'(ready), 0);
        model_reset();
        repeat (2) @(negedge clk1);
        rst_n = 1'b1;
        #1;
        check("rst_release_ready", int'(ready), 0);
    endtask

    // monitor / scoreboard
    always @(negedge clk1) begin
        if (rst_n) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out actual=%0h required=no_output (t=%0t)", out, $time);
                end else begin
                    check("out_value", int'(out), int'(exp_q.pop_front()));
                    check("out_cycle", cyc, exp_cyc_q.pop_front());
                end
            end else begin
                check("out_idle_zero", int'(out), 0);
                if (exp_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
                    checks++;
                    failures++;
                    $display("FAIL missing_out actual=none required=%0h (t=%0t)", exp_q[0], $time);
                    void'(exp_q.pop_front());
                    void'(exp_cyc_q.pop_front());
                end
            end
        end
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk1);
        check("init_out", int'(out), 0);
        check("init_out_valid", int'(out_valid), 0);
        check("init_ready", int'(ready), 0);
        rst_n = 1'b1;
        #1;
        check("init_release_ready", int'(ready), 0);

        // fill then select with a size tie between door1 and door3
        step(1, 0, 1, 10, 0, 0, 0, 0, 0);
        step(1, 0, 2, 50, 0, 0, 0, 0, 0);
        step(1, 0, 3, 30, 0, 0, 0, 0, 0);
        step(1, 0, 4, 50, 0, 0, 0, 0, 0);
        step(1, 0, 5, 20, 0, 0, 0, 0, 0);
        step(1, 0, 6, 0, 0, 0, 1, 0, 0);
        idle(2);
        step(1, 0, 11, 40, 0, 0, 1, 0, 0);
        idle(2);

        // full-scale arithmetic
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(6);
        step(1, 0, 1, 255, 255, 254, 0, 0, 0);
        step(1, 0, 2, 1, 1, 1, 0, 0, 0);
        step(1, 0, 3, 255, 255, 255, 0, 0, 0);
        step(1, 0, 4, 2, 2, 2, 0, 0, 0);
        step(1, 0, 5, 3, 3, 3, 0, 0, 0);
        step(1, 0, 10, 0, 0, 0, 7, 7, 7);
        idle(2);

        // partial drain
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(6);
        step(1, 0, 7, 0, 5, 0, 0, 1, 0);
        step(1, 0, 8, 0, 9, 0, 0, 1, 0);
        step(1, 0, 9, 0, 1, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(4);
        for (int i = 0; i < 5; i++) rand_step(1, 0);
        idle(2);

        // simultaneous in_valid and drain with two slots filled
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(6);
        rand_step(1, 0);
        rand_step(1, 0);
        rand_step(1, 1);
        idle(4);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(5);

        // throughput: in_valid held high in RUN
        for (int i = 0; i < 5; i++) rand_step(1, 0);
        for (int i = 0; i < 40; i++) rand_step(1, 0);
        idle(3);

        // random mix
        for (int i = 0; i < 300; i++)
            rand_step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
        idle(8);

        // reset mid-CALC
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(6);
        for (int i = 0; i < 5; i++) rand_step(1, 0);
        rand_step(1, 0);
        do_reset();
        for (int i = 0; i < 5; i++) rand_step(1, 0);
        idle(3);

        // reset mid-DRAIN
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        do_reset();
        for (int i = 0; i < 5; i++) rand_step(1, 0);
        rand_step(1, 0);
        idle(6);

        check("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
